// File: rtl/exe_muldiv.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// One iteration per cycle; every operation takes exactly WIDTH+1 edges from Start to Done.
module exe_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       Md_op,
    input  logic [WIDTH-1:0] Read_data_1,
    input  logic [WIDTH-1:0] Read_data_2,
    input  logic             Mthi,
    input  logic             Mtlo,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic             Div_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    // state | meaning
    // IDLE  | waiting for Start; Mthi/Mtlo accepted
    // CALC  | one shift-add / shift-subtract step per cycle, WIDTH cycles
    // FIX   | sign correction, HI/LO write, Done pulse
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           r_state, w_next;
    logic             w_load, w_iter, w_write;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_m, r_q, r_a_raw;
    logic [WIDTH:0]   r_rem;
    logic             r_is_div, r_neg_q, r_neg_r, r_dz;

    logic             w_signed, w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic [WIDTH:0]   w_add, w_shl, w_sub;
    logic [2*WIDTH-1:0] w_prod, w_prod_s;
    logic [WIDTH-1:0] w_quo, w_remd;
    logic             w_mt_ok;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_iter  = 1'b0;
        w_write = 1'b0;
        case (r_state)
            IDLE: if (Start && !Flush) begin
                w_load = 1'b1;
                w_next = CALC;
            end
            CALC: if (Flush) begin
                w_next = IDLE;
            end else begin
                w_iter = 1'b1;
                if (r_cnt == LAST) w_next = FIX;
            end
            FIX: begin
                w_next  = IDLE;
                w_write = !Flush;
            end
            default: w_next = IDLE;
        endcase
    end

    assign Busy = (r_state != IDLE);

    // MULT and DIV (Md_op[0] == 0) work on magnitudes and fix signs in FIX
    assign w_signed = ~Md_op[0];
    assign w_a_neg  = w_signed & Read_data_1[WIDTH-1];
    assign w_b_neg  = w_signed & Read_data_2[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -Read_data_1 : Read_data_1;
    assign w_b_mag  = w_b_neg ? -Read_data_2 : Read_data_2;

    assign w_add = r_rem + (r_q[0] ? {1'b0, r_m} : '0);
    assign w_shl = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_sub = w_shl - {1'b0, r_m};

    assign w_prod   = {r_rem[WIDTH-1:0], r_q};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quo    = r_neg_q ? -r_q : r_q;
    assign w_remd   = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    assign w_mt_ok = (r_state == IDLE) && !Start;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_m      <= '0;
            r_q      <= '0;
            r_rem    <= '0;
            r_a_raw  <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
        end else if (w_load) begin
            r_cnt    <= '0;
            r_m      <= w_b_mag;
            r_q      <= w_a_mag;
            r_rem    <= '0;
            r_a_raw  <= Read_data_1;
            r_is_div <= Md_op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dz     <= Md_op[1] && (Read_data_2 == '0);
        end else if (w_iter) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_is_div) begin
                // restoring step: keep the subtraction only when it did not borrow
                if (!w_sub[WIDTH]) begin
                    r_rem <= w_sub;
                    r_q   <= {r_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_rem <= w_shl;
                    r_q   <= {r_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                r_rem <= {1'b0, w_add[WIDTH:1]};
                r_q   <= {w_add[0], r_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            HI       <= '0;
            LO       <= '0;
            Done     <= 1'b0;
            Div_zero <= 1'b0;
        end else begin
            Done <= w_write;
            if (w_write) begin
                Div_zero <= r_is_div && r_dz;
                if (r_is_div && r_dz) begin
                    HI <= r_a_raw;
                    LO <= '1;
                end else if (r_is_div) begin
                    HI <= w_remd;
                    LO <= w_quo;
                end else begin
                    HI <= w_prod_s[2*WIDTH-1:WIDTH];
                    LO <= w_prod_s[WIDTH-1:0];
                end
            end else if (w_mt_ok) begin
                if (Mthi) HI <= Read_data_1;
                if (Mtlo) LO <= Read_data_1;
            end
        end
    end

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv: 32-bit instance for most scenarios, 8-bit instance for width scaling.
module tb_exe_muldiv;
    logic        clock, reset;
    logic        start, mthi, mtlo, flush;
    logic [1:0]  md_op;
    logic [31:0] rd1, rd2;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    logic        start8, zero8;
    logic [1:0]  md_op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    int n_cmp = 0;
    int n_bad = 0;

    exe_muldiv #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .Start(start), .Md_op(md_op),
        .Read_data_1(rd1), .Read_data_2(rd2), .Mthi(mthi), .Mtlo(mtlo),
        .Flush(flush), .Busy(busy), .Done(done), .Div_zero(dz), .HI(hi), .LO(lo)
    );

    exe_muldiv #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .Start(start8), .Md_op(md_op8),
        .Read_data_1(a8), .Read_data_2(b8), .Mthi(zero8), .Mtlo(zero8),
        .Flush(zero8), .Busy(busy8), .Done(done8), .Div_zero(dz8), .HI(hi8), .LO(lo8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        md_op = op; rd1 = a; rd2 = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges, output int bcnt);
        edges = -1; bcnt = 0;
        if (busy) bcnt++;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock); #1;
            if (done) begin edges = i; break; end
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clock); #1;
        n_cmp++; if (hi !== 32'h0)   begin n_bad++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'h0)   begin n_bad++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (dz !== 1'b0)    begin n_bad++; $display("FAIL reset_dz: got %b want 0", dz); end
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_multu_max;
        int e, b;
        start_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(e, b);
        n_cmp++; if (e !== 33)            begin n_bad++; $display("FAIL multu_latency: got %0d want 33", e); end
        n_cmp++; if (b !== 33)            begin n_bad++; $display("FAIL multu_busy_cycles: got %0d want 33", b); end
        n_cmp++; if (hi !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        n_cmp++; if (lo !== 32'h00000001) begin n_bad++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL multu_busy_end: got %b want 0", busy); end
        @(posedge clock); #1;
        n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL multu_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_signed;
        int e, b;
        start_op(2'b00, 32'hFFFFFFFD, 32'd5);
        wait_done(e, b);
        n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_m3x5_hi: got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFFFFF1) begin n_bad++; $display("FAIL mult_m3x5_lo: got %h want fffffff1", lo); end
        start_op(2'b10, 32'hFFFFFFF9, 32'd2);
        wait_done(e, b);
        n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL div_m7d2_lo: got %h want fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL div_m7d2_hi: got %h want ffffffff", hi); end
        n_cmp++; if (e !== 33)            begin n_bad++; $display("FAIL div_latency: got %0d want 33", e); end
    endtask

    task automatic test_div_zero;
        int e, b;
        start_op(2'b11, 32'd5, 32'd0);
        wait_done(e, b);
        n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL divz_lo: got %h want ffffffff", lo); end
        n_cmp++; if (hi !== 32'h00000005) begin n_bad++; $display("FAIL divz_hi: got %h want 00000005", hi); end
        n_cmp++; if (dz !== 1'b1)         begin n_bad++; $display("FAIL divz_flag: got %b want 1", dz); end
        n_cmp++; if (e !== 33)            begin n_bad++; $display("FAIL divz_latency: got %0d want 33", e); end
        start_op(2'b10, 32'hFFFFFFF8, 32'd0);
        wait_done(e, b);
        n_cmp++; if (hi !== 32'hFFFFFFF8) begin n_bad++; $display("FAIL divz_signed_hi: got %h want fffffff8", hi); end
        n_cmp++; if (lo !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL divz_signed_lo: got %h want ffffffff", lo); end
        start_op(2'b11, 32'd9, 32'd4);
        repeat (5) @(posedge clock); #1;
        n_cmp++; if (dz !== 1'b1)         begin n_bad++; $display("FAIL divz_hold_busy: got %b want 1", dz); end
        wait_done(e, b);
        n_cmp++; if (lo !== 32'd2)        begin n_bad++; $display("FAIL divu_9d4_lo: got %h want 2", lo); end
        n_cmp++; if (hi !== 32'd1)        begin n_bad++; $display("FAIL divu_9d4_hi: got %h want 1", hi); end
        n_cmp++; if (dz !== 1'b0)         begin n_bad++; $display("FAIL divu_9d4_flag: got %b want 0", dz); end
    endtask

    task automatic test_overflow;
        int e, b;
        start_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
        wait_done(e, b);
        n_cmp++; if (lo !== 32'h80000000) begin n_bad++; $display("FAIL ovf_lo: got %h want 80000000", lo); end
        n_cmp++; if (hi !== 32'h0)        begin n_bad++; $display("FAIL ovf_hi: got %h want 0", hi); end
        n_cmp++; if (dz !== 1'b0)         begin n_bad++; $display("FAIL ovf_flag: got %b want 0", dz); end
    endtask

    task automatic test_mthi_mtlo;
        int e, b;
        rd1 = 32'h12345678; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clock); #1;
        mthi = 1'b0; mtlo = 1'b0;
        n_cmp++; if (hi !== 32'h12345678) begin n_bad++; $display("FAIL mt_both_hi: got %h want 12345678", hi); end
        n_cmp++; if (lo !== 32'h12345678) begin n_bad++; $display("FAIL mt_both_lo: got %h want 12345678", lo); end
        rd1 = 32'h0000AAAA; mtlo = 1'b1;
        @(posedge clock); #1;
        mtlo = 1'b0;
        n_cmp++; if (lo !== 32'h0000AAAA) begin n_bad++; $display("FAIL mtlo_lo: got %h want 0000aaaa", lo); end
        n_cmp++; if (hi !== 32'h12345678) begin n_bad++; $display("FAIL mtlo_hi_kept: got %h want 12345678", hi); end
        md_op = 2'b01; rd1 = 32'd2; rd2 = 32'd3; start = 1'b1; mthi = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; mthi = 1'b0;
        n_cmp++; if (hi !== 32'h12345678) begin n_bad++; $display("FAIL start_prio_hi: got %h want 12345678", hi); end
        n_cmp++; if (busy !== 1'b1)       begin n_bad++; $display("FAIL start_prio_busy: got %b want 1", busy); end
        wait_done(e, b);
        n_cmp++; if (hi !== 32'd0)        begin n_bad++; $display("FAIL start_prio_res_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'd6)        begin n_bad++; $display("FAIL start_prio_res_lo: got %h want 6", lo); end
    endtask

    task automatic test_busy_ignore;
        int e, b;
        start_op(2'b01, 32'd7, 32'd6);
        repeat (9) @(posedge clock); #1;
        md_op = 2'b11; rd1 = 32'd100; rd2 = 32'd3; start = 1'b1; mthi = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; mthi = 1'b0;
        n_cmp++; if (hi === 32'd100)      begin n_bad++; $display("FAIL busy_mthi: got %h want not 00000064", hi); end
        wait_done(e, b);
        n_cmp++; if (e !== 23)            begin n_bad++; $display("FAIL busy_latency: got %0d want 23", e); end
        n_cmp++; if (hi !== 32'd0)        begin n_bad++; $display("FAIL busy_res_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'd42)       begin n_bad++; $display("FAIL busy_res_lo: got %h want 2a", lo); end
    endtask

    task automatic test_flush;
        int nd;
        rd1 = 32'h0000CAFE; mthi = 1'b1;
        @(posedge clock); #1;
        mthi = 1'b0; rd1 = 32'h0000BEEF; mtlo = 1'b1;
        @(posedge clock); #1;
        mtlo = 1'b0;
        start_op(2'b01, 32'd3, 32'd4);
        repeat (10) @(posedge clock); #1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL flush_busy: got %b want 0", busy); end
        n_cmp++; if (hi !== 32'h0000CAFE) begin n_bad++; $display("FAIL flush_hi: got %h want 0000cafe", hi); end
        n_cmp++; if (lo !== 32'h0000BEEF) begin n_bad++; $display("FAIL flush_lo: got %h want 0000beef", lo); end
        nd = 0;
        repeat (40) begin @(posedge clock); #1; if (done) nd++; end
        n_cmp++; if (nd !== 0)            begin n_bad++; $display("FAIL flush_no_done: got %0d want 0", nd); end
        start_op(2'b01, 32'd3, 32'd4);
        repeat (32) @(posedge clock); #1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL flush_fix_done: got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL flush_fix_busy: got %b want 0", busy); end
        n_cmp++; if (lo !== 32'h0000BEEF) begin n_bad++; $display("FAIL flush_fix_lo: got %h want 0000beef", lo); end
        md_op = 2'b01; flush = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0; start = 1'b0;
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL flush_start_idle: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int e, b;
        start_op(2'b00, 32'h7FFFFFFF, 32'hFFFFFFFF);
        wait_done(e, b);
        n_cmp++; if (hi !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL b2b_mult_hi: got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'h80000001) begin n_bad++; $display("FAIL b2b_mult_lo: got %h want 80000001", lo); end
        start_op(2'b10, 32'd7, 32'hFFFFFFFE);
        wait_done(e, b);
        n_cmp++; if (e !== 33)            begin n_bad++; $display("FAIL b2b_latency: got %0d want 33", e); end
        n_cmp++; if (lo !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL b2b_div_lo: got %h want fffffffd", lo); end
        n_cmp++; if (hi !== 32'h00000001) begin n_bad++; $display("FAIL b2b_div_hi: got %h want 00000001", hi); end
        start_op(2'b00, 32'hFFFFFFFC, 32'hFFFFFFFC);
        wait_done(e, b);
        n_cmp++; if (hi !== 32'd0)        begin n_bad++; $display("FAIL b2b_negneg_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'd16)       begin n_bad++; $display("FAIL b2b_negneg_lo: got %h want 10", lo); end
    endtask

    task automatic test_reset_mid;
        int e, b;
        start_op(2'b11, 32'd1, 32'd0);
        wait_done(e, b);
        start_op(2'b01, 32'hFFFFFFFF, 32'd2);
        repeat (5) @(posedge clock); #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (hi !== 32'h0)        begin n_bad++; $display("FAIL rst_mid_hi: got %h want 0", hi); end
        n_cmp++; if (lo !== 32'h0)        begin n_bad++; $display("FAIL rst_mid_lo: got %h want 0", lo); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_cmp++; if (dz !== 1'b0)         begin n_bad++; $display("FAIL rst_mid_dz: got %b want 0", dz); end
        n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL rst_mid_done: got %b want 0", done); end
        #2;
        reset = 1'b1;
        @(posedge clock); #1;
        start_op(2'b01, 32'd3, 32'd3);
        wait_done(e, b);
        n_cmp++; if (e !== 33)            begin n_bad++; $display("FAIL rst_first_latency: got %0d want 33", e); end
        n_cmp++; if (lo !== 32'd9)        begin n_bad++; $display("FAIL rst_first_lo: got %h want 9", lo); end
        n_cmp++; if (hi !== 32'd0)        begin n_bad++; $display("FAIL rst_first_hi: got %h want 0", hi); end
    endtask

    task automatic test_width8;
        int e;
        md_op8 = 2'b01; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(posedge clock); #1;
        start8 = 1'b0;
        e = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clock); #1;
            if (done8) begin e = i; break; end
        end
        n_cmp++; if (e !== 9)             begin n_bad++; $display("FAIL w8_latency: got %0d want 9", e); end
        n_cmp++; if (hi8 !== 8'hFE)       begin n_bad++; $display("FAIL w8_multu_hi: got %h want fe", hi8); end
        n_cmp++; if (lo8 !== 8'h01)       begin n_bad++; $display("FAIL w8_multu_lo: got %h want 01", lo8); end
        md_op8 = 2'b10; a8 = 8'h80; b8 = 8'hFF; start8 = 1'b1;
        @(posedge clock); #1;
        start8 = 1'b0;
        e = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clock); #1;
            if (done8) begin e = i; break; end
        end
        n_cmp++; if (e !== 9)             begin n_bad++; $display("FAIL w8_div_latency: got %0d want 9", e); end
        n_cmp++; if (lo8 !== 8'h80)       begin n_bad++; $display("FAIL w8_ovf_lo: got %h want 80", lo8); end
        n_cmp++; if (hi8 !== 8'h00)       begin n_bad++; $display("FAIL w8_ovf_hi: got %h want 00", hi8); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
        md_op = 2'b00; rd1 = '0; rd2 = '0;
        start8 = 1'b0; zero8 = 1'b0; md_op8 = 2'b00; a8 = '0; b8 = '0;
        test_reset;
        test_multu_max;
        test_signed;
        test_div_zero;
        test_overflow;
        test_mthi_mtlo;
        test_busy_ignore;
        test_flush;
        test_back_to_back;
        test_reset_mid;
        test_width8;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
